// File: rtl/prog_lut_eval_pkg.sv
// Shared types and sizing helpers for the programmable truth-table evaluator.
package prog_lut_pkg;

  // RUN evaluates requests; LOAD shifts in a new table image.
  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Total number of table bits across all output channels.
  function automatic int tbl_bits(input int n_in, input int n_out);
    return n_out << n_in;
  endfunction

  // Width of the load bit counter, with one spare bit of headroom.
  function automatic int cnt_width(input int total);
    return $clog2(total) + 1;
  endfunction

endpackage

// File: rtl/prog_lut_eval_if.sv
// Config and evaluation handshake bundle for prog_lut_eval.
// master = host/bench side, slave = the evaluator.
interface prog_lut_eval_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) ();

  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_done;

  logic             in_valid;
  logic [N_IN-1:0]  in_data;
  logic             in_ready;

  logic             out_valid;
  logic [N_OUT-1:0] out_data;
  logic             out_ready;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/prog_lut_eval_lut_channel.sv
// One output channel: live minterm table, its pending load image and the
// lookup mux. The live table only changes on commit, so a partial load
// never disturbs evaluation. With PROG_LUT_READBACK_EN the live table is
// exported for readback.
module lut_channel #(
  parameter int N_IN = 3,
  localparam int DEPTH = 1 << N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             img_we_i,
  input  logic [N_IN-1:0]  img_addr_i,
  input  logic             img_bit_i,
  input  logic             commit_i,
  input  logic [N_IN-1:0]  lookup_addr_i,
  output logic             lookup_o
`ifdef PROG_LUT_READBACK_EN
  ,
  output logic [DEPTH-1:0] table_o
`endif
);

  logic [DEPTH-1:0] image_q, image_d;
  logic [DEPTH-1:0] live_q;

  // Merge the incoming bit into the image so the last bit can commit in the same edge.
  always_comb begin
    image_d = image_q;
    if (img_we_i) begin
      image_d[img_addr_i] = img_bit_i;
    end
  end

  // Image and live table registers; live table takes the merged image on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_q <= '0;
      live_q  <= '0;
    end else begin
      image_q <= image_d;
      if (commit_i) begin
        live_q <= image_d;
      end
    end
  end

  assign lookup_o = live_q[lookup_addr_i];

`ifdef PROG_LUT_READBACK_EN
  assign table_o = live_q;
`endif

endmodule

// File: rtl/prog_lut_eval.sv
// Runtime-programmable truth-table evaluator: N_OUT channels of 2^N_IN-entry
// minterm tables loaded serially, evaluated through a one-deep registered
// valid/ready stage. Optional feature macro: PROG_LUT_READBACK_EN adds the
// cfg_dout port, which streams out the old live-table bit for each accepted
// config bit.
module prog_lut_eval
  import prog_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_lut_eval_if.slave    bus
`ifdef PROG_LUT_READBACK_EN
  ,
  output logic              cfg_dout
`endif
);

  localparam int DEPTH = 1 << N_IN;
  localparam int TOTAL = tbl_bits(N_IN, N_OUT);
  localparam int CW    = cnt_width(TOTAL);
  localparam int IW    = $clog2(TOTAL);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cfg_done_q, cfg_done_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_data_q, out_data_d;

  logic             cfg_accept;
  logic             last_bit;
  logic             commit;
  logic             img_we;
  logic             in_ready;
  logic             eval_accept;
  logic [N_OUT-1:0] lookup;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    chan_idx;

  assign bit_idx     = cnt_q[IW-1:0];
  assign chan_idx    = bit_idx >> N_IN;
  assign cfg_accept  = (state_q == LOAD) && bus.cfg_valid;
  assign last_bit    = (cnt_q == CW'(TOTAL - 1));
  assign img_we      = cfg_accept && !bus.cfg_start;
  assign in_ready    = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign eval_accept = bus.in_valid && in_ready;

  // Load sequencing: a restart always wins over committing the final bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_done_d = 1'b0;
    commit     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          cnt_d = '0;
        end else if (bus.cfg_valid) begin
          if (last_bit) begin
            commit     = 1'b1;
            cfg_done_d = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, bit counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef PROG_LUT_READBACK_EN
  logic [TOTAL-1:0] live_all;
`endif

  // Channel c owns config bits c*DEPTH .. c*DEPTH+DEPTH-1, minterm 0 first.
  for (genvar c = 0; c < N_OUT; c++) begin : g_chan
    lut_channel #(
      .N_IN (N_IN)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .img_we_i      (img_we && (chan_idx == IW'(c))),
      .img_addr_i    (bit_idx[N_IN-1:0]),
      .img_bit_i     (bus.cfg_bit),
      .commit_i      (commit),
      .lookup_addr_i (bus.in_data),
      .lookup_o      (lookup[c])
`ifdef PROG_LUT_READBACK_EN
      ,
      .table_o       (live_all[c*DEPTH +: DEPTH])
`endif
    );
  end

  // Output stage: capture on accept, drop valid once consumed, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (eval_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef PROG_LUT_READBACK_EN
  logic cfg_dout_q;

  // Readback: emit the live bit at the position being overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_dout_q <= 1'b0;
    end else if (cfg_accept) begin
      cfg_dout_q <= live_all[bit_idx];
    end
  end

  assign cfg_dout = cfg_dout_q;
`endif

  assign bus.cfg_ready = (state_q == LOAD);
  assign bus.cfg_done  = cfg_done_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_prog_lut_eval.sv
// Directed self-checking bench for prog_lut_eval (N_IN=3, N_OUT=1).
// Readback checks are compiled in when PROG_LUT_READBACK_EN is defined.
module tb_prog_lut_eval;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1;

  logic clk;
  logic rst_n;
`ifdef PROG_LUT_READBACK_EN
  logic cfg_dout;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  prog_lut_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  prog_lut_eval #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PROG_LUT_READBACK_EN
    ,
    .cfg_dout (cfg_dout)
`endif
  );

  // 10-unit free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every host-side input at once.
  task automatic applyStimulus(input logic cs, input logic cv, input logic cb,
                               input logic iv, input logic [2:0] id, input logic ordy);
    bus.cfg_start = cs;
    bus.cfg_valid = cv;
    bus.cfg_bit   = cb;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse cfg_start; LOAD is visible from the next cycle.
  task automatic startLoad();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    checkOutput("load_cfg_ready", 8'(bus.cfg_ready), 8'd1);
    checkOutput("load_in_ready", 8'(bus.in_ready), 8'd0);
  endtask

  // Send table bits lo..hi (minterm order); bit 7 is the committing bit.
  task automatic sendBits(input logic [7:0] newTbl, input logic [7:0] oldTbl, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(1'b0, 1'b1, newTbl[i], 1'b0, 3'd0, 1'b1);
      tick();
      checkOutput($sformatf("cfg_done_bit%0d", i), 8'(bus.cfg_done), (i == 7) ? 8'd1 : 8'd0);
`ifdef PROG_LUT_READBACK_EN
      checkOutput($sformatf("cfg_dout_bit%0d", i), 8'(cfg_dout), 8'(oldTbl[i]));
`else
      if (oldTbl[i] === 1'bx) $display("[TB] note: unknown old bit %0d", i);
`endif
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  // Evaluate minterms 0..7 back-to-back and compare against a hand table.
  task automatic evalSweep(input logic [7:0] expTbl);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'(i), 1'b1);
      tick();
      checkOutput($sformatf("sweep_valid_m%0d", i), 8'(bus.out_valid), 8'd1);
      checkOutput($sformatf("sweep_data_m%0d", i), 8'(bus.out_data), 8'(expTbl[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("sweep_drain_valid", 8'(bus.out_valid), 8'd0);
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    tick();
    checkOutput("rst_out_valid", 8'(bus.out_valid), 8'd0);
    checkOutput("rst_out_data", 8'(bus.out_data), 8'd0);
    checkOutput("rst_cfg_done", 8'(bus.cfg_done), 8'd0);
    checkOutput("rst_cfg_ready", 8'(bus.cfg_ready), 8'd0);
    checkOutput("rst_in_ready", 8'(bus.in_ready), 8'd1);
`ifdef PROG_LUT_READBACK_EN
    checkOutput("rst_cfg_dout", 8'(cfg_dout), 8'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Empty table evaluates to 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    checkOutput("eval0_valid", 8'(bus.out_valid), 8'd1);
    checkOutput("eval0_data", 8'(bus.out_data), 8'd0);
    tick();
    checkOutput("eval0_drop", 8'(bus.out_valid), 8'd0);

    // Minterms {0,1,3,5,7}.
    startLoad();
    sendBits(8'hAB, 8'h00, 0, 7);
    checkOutput("commit_cfg_ready", 8'(bus.cfg_ready), 8'd0);
    evalSweep(8'hAB);
    checkOutput("done_single_pulse", 8'(bus.cfg_done), 8'd0);

    // Backpressure: hold the result of minterm 3 for three cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
    tick();
    checkOutput("bp_first_data", 8'(bus.out_data), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    #1;
    checkOutput("bp_in_ready_low", 8'(bus.in_ready), 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp_hold_valid%0d", i), 8'(bus.out_valid), 8'd1);
      checkOutput($sformatf("bp_hold_data%0d", i), 8'(bus.out_data), 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    #1;
    checkOutput("bp_in_ready_release", 8'(bus.in_ready), 8'd1);
    tick();
    checkOutput("bp_next_valid", 8'(bus.out_valid), 8'd1);
    checkOutput("bp_next_data", 8'(bus.out_data), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("bp_drain", 8'(bus.out_valid), 8'd0);

    // Partial load of {2,3,6,7}, blocked eval, then restart and full load.
    startLoad();
    sendBits(8'hCC, 8'hAB, 0, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
    #1;
    checkOutput("blocked_in_ready", 8'(bus.in_ready), 8'd0);
    tick();
    checkOutput("blocked_out_valid", 8'(bus.out_valid), 8'd0);
    startLoad();
    sendBits(8'hCC, 8'hAB, 0, 7);
    evalSweep(8'hCC);

    // cfg_start on the final bit cancels the commit.
    startLoad();
    sendBits(8'hFF, 8'hCC, 0, 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    checkOutput("restart_no_done", 8'(bus.cfg_done), 8'd0);
    checkOutput("restart_still_load", 8'(bus.cfg_ready), 8'd1);
    sendBits(8'h0F, 8'hCC, 0, 7);
    evalSweep(8'h0F);

    // A result pending when LOAD begins is kept until consumed.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("retain_valid", 8'(bus.out_valid), 8'd1);
    checkOutput("retain_data", 8'(bus.out_data), 8'd1);
    checkOutput("retain_cfg_ready", 8'(bus.cfg_ready), 8'd1);
    tick();
    checkOutput("retain_hold", 8'(bus.out_valid), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("retain_consumed", 8'(bus.out_valid), 8'd0);

    // Reset in the middle of a load clears the tables.
    sendBits(8'hF0, 8'h0F, 0, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cfg_ready", 8'(bus.cfg_ready), 8'd0);
    checkOutput("midrst_in_ready", 8'(bus.in_ready), 8'd1);
    checkOutput("midrst_out_valid", 8'(bus.out_valid), 8'd0);
    checkOutput("midrst_cfg_done", 8'(bus.cfg_done), 8'd0);
`ifdef PROG_LUT_READBACK_EN
    checkOutput("midrst_cfg_dout", 8'(cfg_dout), 8'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    evalSweep(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/prog_lut_eval.md
# prog_lut_eval

Parametrised, runtime-programmable truth-table evaluator. It holds one 2^N_IN-entry minterm table per output channel. Tables are loaded serially over a config handshake, and input vectors are evaluated through a registered valid/ready stream. It replaces the fixed, hard-wired boolean-function blocks in the combinational/sequential lab set, so that any sum-of-minterms function can be loaded without re-synthesis.

## Interface
- N_IN, default 3: input variable count; table depth per channel is 2^N_IN (N_IN in 1..6).
- N_OUT, default 1: output channel count; each channel has an independent table.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock, async active-low reset: fixed.
- cfg_start  in  1  single-cycle pulse; (re)starts a table load.
- cfg_valid  in  1  cfg_bit is valid.
- cfg_bit  in  1  serial table bit.
- cfg_ready  out  1  bit accepted when cfg_valid && cfg_ready.
- cfg_done  out  1  one-cycle pulse when the last table bit is accepted.
- in_valid  in  1  evaluation request valid.
- in_data  in  N_IN  variable vector; bit N_IN-1 = MSB variable (A in the 3-input case).
- in_ready  out  1  request accepted when in_valid && in_ready.
- out_valid  out  1  result valid.
- out_data  out  N_OUT  result; bit k = table_k[in_data].
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states:
  - RUN: evaluation enabled.
  - LOAD: config shifting.
- Reset values:
  - State = RUN.
  - All tables = 0.
  - Bit counter = 0.
  - out_valid = 0, out_data = 0, cfg_done = 0.
  - cfg_ready = 0, in_ready = 1.
- RUN to LOAD on cfg_start. The counter clears, and cfg_ready = 1 from the next cycle.
- LOAD:
  - Each accepted bit shifts into the load image.
  - Bit order: channel 0 first; within a channel, minterm 0 first and minterm 2^N_IN-1 last.
  - Total bits = N_OUT·2^N_IN. The counter width is clog2 of that +1.
- Last bit accepted: the image commits to the live tables in the same edge, cfg_done pulses, and the state returns to RUN.
- Until commit, the live tables keep their old contents. A partial load never alters function.
- cfg_start while in LOAD: the counter restarts at 0 and the partial image is discarded.
- cfg_start in the same cycle as the last bit: the restart wins. No commit, no cfg_done.
- cfg_valid while not in LOAD is ignored.
- in_ready = (state == RUN) && (!out_valid || out_ready), so requests are blocked during LOAD.
- On accept: out_data ← lookup of in_data in every channel; out_valid ← 1.
- out_valid clears when out_ready && !(new accept).
- out_data and out_valid hold stable while out_valid && !out_ready.
- A result already in the output register when LOAD begins is retained until consumed. It reflects the old table.
- Reset mid-load: the tables return to 0 (not the old table), and the state returns to RUN.

## Timing
- Evaluate latency: 1 cycle. A request accepted at edge t gives out_valid at t (registered) and is visible in cycle t+1.
- Full throughput: one result per cycle when out_ready stays high.
- Load takes N_OUT·2^N_IN accepted bits plus 1 cycle for cfg_start. The first eval after cfg_done is accepted the cycle after commit.
- No combinational path from in_valid/in_data to out_*. in_ready depends combinationally on out_ready.

## Configuration
- PROG_LUT_READBACK_EN defined:
  - Adds an output port cfg_dout (1 bit, reset 0).
  - On each accepted cfg bit, cfg_dout registers the live-table bit at the same position.
  - This lets a bench or host read the old table while writing a new one. Chained devices can be daisy-chained.
- Undefined: the port is absent and there is no readback logic.

## Structure
- Package prog_lut_pkg:
  - State enum (RUN, LOAD).
  - Function tbl_bits(n_in, n_out) = n_out<<n_in.
  - Count-width helper.
- One sub-module, lut_channel: holds one live table and one load-image slice, and performs the mux lookup. It is instantiated N_OUT times by generate; the top keeps the FSM, counter and output register.

## Test plan
- Reset, then eval in_data=3'b101 (N_IN=3, N_OUT=1) → out_data=0 one cycle later; cfg_ready=0, in_ready=1.
- Load bits for minterms {0,1,3,5,7} (sequence 1,1,0,1,0,1,0,1), then eval 0..7 back-to-back → out_data 1,1,0,1,0,1,0,1 on consecutive cycles; cfg_done pulses once.
- Hold out_ready=0 for 3 cycles with in_valid high → in_ready=0, out_data frozen; release → the next result follows with no loss.
- Load 5 bits of {2,3,6,7}, pulse cfg_start, then load {2,3,6,7} in full → eval yields 0,0,1,1,0,0,1,1; the intermediate eval is blocked.
- Assert rst_n low after 4 load bits → all outputs return to reset values and the table reads all zero.
- With PROG_LUT_READBACK_EN, load {0,1,3,5,7}, then reload {2,3,6,7} → cfg_dout streams 1,1,0,1,0,1,0,1.
